ddr3_odt_seq: RTL and testbench
===============================

DDR3_ODT_SEQ -- requirements
Module: ddr3_odt_seq

Interface
REQ-001 SHALL expose parameter NUM_RANKS, default 2, number of ODT pins/ranks driven (1..4).
REQ-002 SHALL expose parameter MAX_ODT_LAT, default 16, largest honoured ODT latency in DRAM clocks.
REQ-003 SHALL expose parameter STEP_GAP, default 2, idle fabric cycles between delay-line MOVE pulses (>=1).
REQ-004 SHALL define RANK_W = max(1, clog2(NUM_RANKS)); one clock; reset is synchronous and active-high.
REQ-005 FAB_CLK  in  1  fabric clock; one cycle = 4 DRAM clock slots.
REQ-006 TX_SYNC_RST  in  1  synchronous active-high reset.
REQ-007 CFG_ODT_LAT  in  5  ODT assertion latency in DRAM clocks, quasi-static.
REQ-008 CFG_ODT_LEN  in  4  ODT assertion length in DRAM clocks, quasi-static.
REQ-009 WR_CMD_VALID  in  1  write command issued this fabric cycle.
REQ-010 WR_CMD_SLOT  in  2  DRAM slot (0..3) of the command within the fabric cycle.
REQ-011 WR_ODT_MASK  in  NUM_RANKS  ranks whose ODT assert for this command.
REQ-012 TX_DATA  out  4*NUM_RANKS  per-rank 4-slot ODT word; bit 4r+k = rank r, slot k.
REQ-013 OE_DATA  out  4*NUM_RANKS  per-rank output enables.
REQ-014 DL_REQ, DL_RANK[RANK_W], DL_DIR, DL_LOAD, DL_STEPS[8]  in  delay-line adjust request and arguments.
REQ-015 DL_BUSY, DL_DONE, DL_ERR  out  1 each  adjust status.
REQ-016 DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD  out  NUM_RANKS  per-rank IOD delay controls.
REQ-017 DELAY_LINE_OUT_OF_RANGE  in  NUM_RANKS  per-rank IOD range flag.

Function
REQ-018 Command at cycle t, slot p SHALL assert ODT for rank r in WR_ODT_MASK on absolute slots S = 4t+p+L+i, i = 0..CFG_ODT_LEN-1, L = min(CFG_ODT_LAT, MAX_ODT_LAT).
REQ-019 Slot S SHALL appear on TX_DATA bit 4r+(S mod 4) during fabric cycle floor(S/4)+1 (one registered stage).
REQ-020 Overlapping windows from multiple commands SHALL be ORed; no window shall truncate another.
REQ-021 CFG_ODT_LEN = 0 SHALL produce no ODT assertion; commands with WR_ODT_MASK = 0 SHALL be no-ops.
REQ-022 OE_DATA SHALL be all ones from the first cycle after reset deasserts.
REQ-023 Adjust FSM states: IDLE, LOAD, MOVE, GAP, DONE.
REQ-024 IDLE: DL_REQ=1 SHALL latch DL_RANK, DL_DIR, DL_LOAD, DL_STEPS, set DL_BUSY next cycle, go LOAD if DL_LOAD else MOVE (DONE if DL_STEPS=0).
REQ-025 LOAD: one-cycle DELAY_LINE_LOAD pulse on latched rank, then MOVE (or DONE if steps=0).
REQ-026 MOVE: one-cycle DELAY_LINE_MOVE pulse, decrement count; then GAP for STEP_GAP cycles; return to MOVE while count>0, else DONE.
REQ-027 DELAY_LINE_DIRECTION of latched rank SHALL equal latched DL_DIR for the whole operation; other ranks 0.
REQ-028 DELAY_LINE_OUT_OF_RANGE of latched rank high in MOVE or GAP SHALL abort to DONE with DL_ERR=1; no further MOVE.
REQ-029 DONE: DL_DONE one-cycle pulse, DL_ERR valid with it, DL_BUSY cleared same cycle, return to IDLE.
REQ-030 DL_REQ while DL_BUSY SHALL be ignored; DL_RANK >= NUM_RANKS SHALL go directly to DONE with DL_ERR=1.
REQ-031 ODT path and adjust FSM SHALL operate independently and concurrently.

Reset
REQ-032 TX_SYNC_RST=1 SHALL clear all ODT shift state, TX_DATA=0, OE_DATA=0, all DELAY_LINE_* =0, DL_BUSY/DL_DONE/DL_ERR=0, FSM=IDLE.
REQ-033 Reset SHALL take priority over a same-cycle command or DL_REQ; reset mid-window or mid-adjust SHALL discard pending activity.

Configuration
REQ-034 Macro DDR3_ODT_SEQ_DLY_STEP_EN defined: adjust FSM built as above.
REQ-035 Macro undefined: no FSM; DELAY_LINE_* outputs tied 0, DL_BUSY=0; DL_REQ SHALL pulse DL_DONE with DL_ERR=1 the next cycle.

Verification
REQ-036 LAT=5, LEN=4, cmd t=10 slot 1 mask 01 -> rank0 slots 46..49: TX_DATA[3:0]=4'b1100 cycle 12, 4'b0011 cycle 13; rank1 0.
REQ-037 LAT=0, LEN=6, cmds t=4 slot 3 and t=5 slot 1, mask 11 -> both ranks continuous slots 19..26 (cycles 5..7), no gap.
REQ-038 LAT=20 (>MAX 16) -> clamped to 16; LEN=0 -> TX_DATA stays 0.
REQ-039 DL_REQ rank1, LOAD=1, DIR=1, STEPS=3, GAP=2 -> LOAD pulse, MOVE pulses 3 cycles apart, DL_DONE, DL_ERR=0, 13 cycles total from request.
REQ-040 OUT_OF_RANGE rises after second MOVE -> no third MOVE, DL_DONE with DL_ERR=1; reset during GAP -> all outputs 0 next cycle, FSM IDLE.
REQ-041 Build without DDR3_ODT_SEQ_DLY_STEP_EN: DL_REQ -> DL_DONE=1, DL_ERR=1 next cycle, DELAY_LINE_MOVE never asserts.

Source files
------------

// File: rtl/ddr3_odt_seq.sv
// DDR3 write-ODT sequencer (4 DRAM slots per fabric cycle) plus per-rank IODELAY adjust engine.
// The adjust FSM is built only when DDR3_ODT_SEQ_DLY_STEP_EN is defined; otherwise requests are refused with an error.
module ddr3_odt_seq #(
    parameter int NUM_RANKS   = 2,
    parameter int MAX_ODT_LAT = 16,
    parameter int STEP_GAP    = 2,
    localparam int RANK_W     = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
    input  logic                   fab_clk_i,
    input  logic                   tx_sync_rst_i,
    input  logic [4:0]             cfg_odt_lat_i,
    input  logic [3:0]             cfg_odt_len_i,
    input  logic                   wr_cmd_valid_i,
    input  logic [1:0]             wr_cmd_slot_i,
    input  logic [NUM_RANKS-1:0]   wr_odt_mask_i,
    output logic [4*NUM_RANKS-1:0] tx_data_o,
    output logic [4*NUM_RANKS-1:0] oe_data_o,
    input  logic                   dl_req_i,
    input  logic [RANK_W-1:0]      dl_rank_i,
    input  logic                   dl_dir_i,
    input  logic                   dl_load_i,
    input  logic [7:0]             dl_steps_i,
    output logic                   dl_busy_o,
    output logic                   dl_done_o,
    output logic                   dl_err_o,
    output logic [NUM_RANKS-1:0]   delay_line_move_o,
    output logic [NUM_RANKS-1:0]   delay_line_direction_o,
    output logic [NUM_RANKS-1:0]   delay_line_load_o,
    input  logic [NUM_RANKS-1:0]   delay_line_out_of_range_i
);

    // Window reaches at most slot 3 + MAX_ODT_LAT + 15 past the current cycle's first slot.
    localparam int PEND_W = ((3 + MAX_ODT_LAT + 15) / 4 + 1) * 4;

    logic [PEND_W-1:0]      pend_q [NUM_RANKS];
    logic [PEND_W-1:0]      pend_d [NUM_RANKS];
    logic [PEND_W-1:0]      win;
    logic [PEND_W-1:0]      merged;
    logic [7:0]             lat_eff;
    logic [7:0]             win_lo;
    logic [7:0]             win_hi;
    logic [4*NUM_RANKS-1:0] tx_data_d;
    logic [4*NUM_RANKS-1:0] tx_data_q;
    logic [4*NUM_RANKS-1:0] oe_data_q;

    // NOTE: every variable assigned here gets a value before any conditional use, so no latch is inferred.
    always_comb begin
        win       = '0;
        merged    = '0;
        tx_data_d = '0;
        lat_eff   = (int'(cfg_odt_lat_i) > MAX_ODT_LAT) ? 8'(MAX_ODT_LAT) : {3'b000, cfg_odt_lat_i};
        win_lo    = {6'b0, wr_cmd_slot_i} + lat_eff;
        win_hi    = win_lo + {4'b0, cfg_odt_len_i};
        for (int i = 0; i < PEND_W; i++) begin
            win[i] = (8'(i) >= win_lo) && (8'(i) < win_hi);
        end
        for (int r = 0; r < NUM_RANKS; r++) begin
            merged             = pend_q[r] | ((wr_cmd_valid_i && wr_odt_mask_i[r]) ? win : '0);
            tx_data_d[4*r +: 4] = merged[3:0];
            pend_d[r]          = merged >> 4;
        end
    end

    // NOTE: the pending-window store is plain flops, so it is cleared by reset like any other state.
    always_ff @(posedge fab_clk_i) begin
        if (tx_sync_rst_i) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                pend_q[r] <= '0;
            end
            tx_data_q <= '0;
            oe_data_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            tx_data_q <= tx_data_d;
            oe_data_q <= '1;
        end
    end

    assign tx_data_o = tx_data_q;
    assign oe_data_o = oe_data_q;

`ifdef DDR3_ODT_SEQ_DLY_STEP_EN

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } adj_state_e;

    adj_state_e           state_q;
    logic [NUM_RANKS-1:0] sel_q;
    logic [NUM_RANKS-1:0] req_sel;
    logic                 rank_ok;
    logic                 oor_hit;
    logic [7:0]           cnt_q;
    logic [7:0]           gap_q;
    logic                 err_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [NUM_RANKS-1:0] move_q;
    logic [NUM_RANKS-1:0] load_q;
    logic [NUM_RANKS-1:0] dir_q;

    always_comb begin
        req_sel = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            req_sel[r] = (int'(dl_rank_i) == r);
        end
        rank_ok = int'(dl_rank_i) < NUM_RANKS;
        oor_hit = |(delay_line_out_of_range_i & sel_q);
    end

    // Pulse outputs are registered decodes of the current state, so each appears one cycle after its state.
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge fab_clk_i) begin
        if (tx_sync_rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            move_q     <= '0;
            load_q     <= '0;
            dir_q      <= '0;
        end else begin
            move_q <= '0;
            load_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dl_req_i) begin
                        sel_q      <= req_sel;
                        cnt_q      <= dl_steps_i;
                        busy_q     <= 1'b1;
                        err_pend_q <= !rank_ok;
                        dir_q      <= dl_dir_i ? req_sel : '0;
                        if (!rank_ok)              state_q <= ST_DONE;
                        else if (dl_load_i)        state_q <= ST_LOAD;
                        else if (dl_steps_i == '0) state_q <= ST_DONE;
                        else                       state_q <= ST_MOVE;
                    end
                end
                ST_LOAD: begin
                    load_q  <= sel_q;
                    state_q <= (cnt_q == '0) ? ST_DONE : ST_MOVE;
                end
                ST_MOVE: begin
                    if (oor_hit) begin
                        err_pend_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        move_q  <= sel_q;
                        cnt_q   <= cnt_q - 8'd1;
                        gap_q   <= 8'(STEP_GAP - 1);
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (oor_hit) begin
                        err_pend_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (gap_q == '0) begin
                        state_q <= (cnt_q != '0) ? ST_MOVE : ST_DONE;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    err_q   <= err_pend_q;
                    busy_q  <= 1'b0;
                    dir_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dl_busy_o              = busy_q;
    assign dl_done_o              = done_q;
    assign dl_err_o               = err_q;
    assign delay_line_move_o      = move_q;
    assign delay_line_load_o      = load_q;
    assign delay_line_direction_o = dir_q;

`else

    logic        dl_done_q;
    logic        unused_adj;
    logic [31:0] unused_gap;

    // Without the adjust engine every request is answered immediately with an error.
    always_ff @(posedge fab_clk_i) begin
        if (tx_sync_rst_i) dl_done_q <= 1'b0;
        else               dl_done_q <= dl_req_i;
    end

    assign unused_adj             = ^{dl_rank_i, dl_dir_i, dl_load_i, dl_steps_i, delay_line_out_of_range_i};
    assign unused_gap             = 32'(STEP_GAP);
    assign dl_busy_o              = 1'b0;
    assign dl_done_o              = dl_done_q;
    assign dl_err_o               = dl_done_q;
    assign delay_line_move_o      = '0;
    assign delay_line_load_o      = '0;
    assign delay_line_direction_o = '0;

`endif

endmodule

// File: tb/tb_ddr3_odt_seq.sv
// Self-checking bench for ddr3_odt_seq: slot-level ODT reference model plus adjust-sequence timing model.
// Adjust FSM scenarios run when DDR3_ODT_SEQ_DLY_STEP_EN is defined, otherwise the refusal path is checked.
module tb_ddr3_odt_seq;

    localparam int NR = 2;
    localparam int ML = 16;
    localparam int SG = 2;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;
    localparam int MAXSLOT = 32768;

    logic            fab_clk      = 1'b0;
    logic            tx_sync_rst  = 1'b1;
    logic [4:0]      cfg_odt_lat  = '0;
    logic [3:0]      cfg_odt_len  = '0;
    logic            wr_cmd_valid = 1'b0;
    logic [1:0]      wr_cmd_slot  = '0;
    logic [NR-1:0]   wr_odt_mask  = '0;
    logic [4*NR-1:0] tx_data;
    logic [4*NR-1:0] oe_data;
    logic            dl_req   = 1'b0;
    logic [RW-1:0]   dl_rank  = '0;
    logic            dl_dir   = 1'b0;
    logic            dl_load  = 1'b0;
    logic [7:0]      dl_steps = '0;
    logic            dl_busy;
    logic            dl_done;
    logic            dl_err;
    logic [NR-1:0]   dl_move;
    logic [NR-1:0]   dl_direction;
    logic [NR-1:0]   dl_loadv;
    logic [NR-1:0]   dl_oor = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // exp_odt[r][S] = 1 when absolute DRAM slot S must carry ODT for rank r.
    bit exp_odt [NR][MAXSLOT];

    ddr3_odt_seq #(
        .NUM_RANKS  (NR),
        .MAX_ODT_LAT(ML),
        .STEP_GAP   (SG)
    ) dut (
        .fab_clk_i                (fab_clk),
        .tx_sync_rst_i            (tx_sync_rst),
        .cfg_odt_lat_i            (cfg_odt_lat),
        .cfg_odt_len_i            (cfg_odt_len),
        .wr_cmd_valid_i           (wr_cmd_valid),
        .wr_cmd_slot_i            (wr_cmd_slot),
        .wr_odt_mask_i            (wr_odt_mask),
        .tx_data_o                (tx_data),
        .oe_data_o                (oe_data),
        .dl_req_i                 (dl_req),
        .dl_rank_i                (dl_rank),
        .dl_dir_i                 (dl_dir),
        .dl_load_i                (dl_load),
        .dl_steps_i               (dl_steps),
        .dl_busy_o                (dl_busy),
        .dl_done_o                (dl_done),
        .dl_err_o                 (dl_err),
        .delay_line_move_o        (dl_move),
        .delay_line_direction_o   (dl_direction),
        .delay_line_load_o        (dl_loadv),
        .delay_line_out_of_range_i(dl_oor)
    );

    always #5 fab_clk = ~fab_clk;

    task automatic tick();
        @(posedge fab_clk);
        #1;
        cyc++;
    endtask

    task automatic clear_model();
        for (int r = 0; r < NR; r++) begin
            for (int s = 0; s < MAXSLOT; s++) exp_odt[r][s] = 1'b0;
        end
    endtask

    // Commands issued in the cycle numbered t cover slots 4t+p+L .. 4t+p+L+len-1.
    task automatic issue(input bit v, input int slot, input logic [NR-1:0] mask);
        int lat_eff;
        wr_cmd_valid = v;
        wr_cmd_slot  = slot[1:0];
        wr_odt_mask  = mask;
        lat_eff = (int'(cfg_odt_lat) > ML) ? ML : int'(cfg_odt_lat);
        if (v && !tx_sync_rst) begin
            for (int r = 0; r < NR; r++) begin
                if (mask[r]) begin
                    for (int i = 0; i < int'(cfg_odt_len); i++) exp_odt[r][4*cyc + slot + lat_eff + i] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [4*NR-1:0] exp_tx(input int c);
        logic [4*NR-1:0] v;
        v = '0;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < 4; k++) v[4*r + k] = exp_odt[r][4*(c-1) + k];
        end
        return v;
    endfunction

    task automatic test_reset();
        cfg_odt_lat = 5'd0;
        cfg_odt_len = 4'd8;
        issue(1'b1, 0, '1);
        dl_req   = 1'b1;
        dl_steps = 8'd3;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({tx_data, oe_data} !== '0) begin
                bad++;
                $display("FAIL reset_odt cyc=%0d got=%h want=0", cyc, {tx_data, oe_data});
            end
            total++;
            if ({dl_busy, dl_done, dl_err, dl_move, dl_direction, dl_loadv} !== '0) begin
                bad++;
                $display("FAIL reset_adj cyc=%0d got=%h want=0", cyc,
                         {dl_busy, dl_done, dl_err, dl_move, dl_direction, dl_loadv});
            end
        end
        tx_sync_rst = 1'b0;
        dl_req      = 1'b0;
        issue(1'b0, 0, '0);
        clear_model();
        tick();
        total++;
        if (oe_data !== '1 || tx_data !== '0) begin
            bad++;
            $display("FAIL reset_release cyc=%0d got oe=%h tx=%h want oe=%h tx=0", cyc, oe_data, tx_data, {4*NR{1'b1}});
        end
        total++;
        if ({dl_busy, dl_done, dl_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release_adj cyc=%0d got=%b want=000", cyc, {dl_busy, dl_done, dl_err});
        end
    endtask

    task automatic test_lat5();
        logic [4*NR-1:0] want [4];
        want[0] = 8'b0000_0000;
        want[1] = 8'b0000_1100;
        want[2] = 8'b0000_0011;
        want[3] = 8'b0000_0000;
        cfg_odt_lat = 5'd5;
        cfg_odt_len = 4'd4;
        issue(1'b1, 1, 2'b01);
        tick();
        issue(1'b0, 0, '0);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (tx_data !== want[n]) begin
                bad++;
                $display("FAIL lat5_window +%0d got=%b want=%b", n + 1, tx_data, want[n]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4*NR-1:0] want [4];
        want[0] = 8'b1000_1000;
        want[1] = 8'b1111_1111;
        want[2] = 8'b0111_0111;
        want[3] = 8'b0000_0000;
        cfg_odt_lat = 5'd0;
        cfg_odt_len = 4'd6;
        issue(1'b1, 3, 2'b11);
        tick();
        issue(1'b1, 1, 2'b11);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (tx_data !== want[n]) begin
                bad++;
                $display("FAIL back_to_back +%0d got=%b want=%b", n + 1, tx_data, want[n]);
            end
            tick();
            issue(1'b0, 0, '0);
        end
    endtask

    task automatic test_clamp();
        logic [4*NR-1:0] want;
        cfg_odt_lat = 5'd20;
        cfg_odt_len = 4'd3;
        issue(1'b1, 0, 2'b10);
        tick();
        issue(1'b0, 0, '0);
        for (int n = 1; n <= 7; n++) begin
            want = (n == 5) ? 8'b0111_0000 : 8'b0000_0000;
            total++;
            if (tx_data !== want) begin
                bad++;
                $display("FAIL lat_clamp +%0d got=%b want=%b", n, tx_data, want);
            end
            tick();
        end
        cfg_odt_len = 4'd0;
        for (int n = 0; n < 24; n++) begin
            issue(n % 3 != 2, n % 4, 2'b11);
            tick();
            total++;
            if (tx_data !== '0) begin
                bad++;
                $display("FAIL len_zero cyc=%0d got=%b want=0", cyc, tx_data);
            end
        end
        issue(1'b0, 0, '0);
    endtask

    task automatic test_reset_window();
        cfg_odt_lat = 5'd16;
        cfg_odt_len = 4'd8;
        issue(1'b1, 2, 2'b11);
        tick();
        issue(1'b0, 0, '0);
        tick();
        tx_sync_rst = 1'b1;
        tick();
        total++;
        if ({tx_data, oe_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_window cyc=%0d got=%h want=0", cyc, {tx_data, oe_data});
        end
        tx_sync_rst = 1'b0;
        clear_model();
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if (tx_data !== '0 || oe_data !== '1) begin
                bad++;
                $display("FAIL reset_discard cyc=%0d got tx=%h oe=%h want tx=0 oe=all ones", cyc, tx_data, oe_data);
            end
        end
    endtask

    task automatic test_random_odt();
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                cfg_odt_lat = 5'($urandom_range(0, 31));
                cfg_odt_len = 4'($urandom_range(0, 15));
            end
            total++;
            if (tx_data !== exp_tx(cyc) || oe_data !== '1) begin
                bad++;
                $display("FAIL random_odt cyc=%0d got=%b want=%b oe=%h", cyc, tx_data, exp_tx(cyc), oe_data);
            end
            issue($urandom_range(0, 2) == 0, $urandom_range(0, 3), NR'($urandom));
            tick();
        end
        issue(1'b0, 0, '0);
        for (int n = 0; n < 12; n++) begin
            total++;
            if (tx_data !== exp_tx(cyc)) begin
                bad++;
                $display("FAIL random_drain cyc=%0d got=%b want=%b", cyc, tx_data, exp_tx(cyc));
            end
            tick();
        end
    endtask

`ifdef DDR3_ODT_SEQ_DLY_STEP_EN

    // Expected adjust timeline, counted from the request cycle (rel 0): the first pulse lands at rel 2,
    // MOVE pulses are STEP_GAP+1 apart, DL_DONE follows STEP_GAP+1 after the last MOVE pulse.
    // An out-of-range flag seen at rel X ends the operation with DL_DONE at rel X+2.
    task automatic run_adjust(input int rank, input bit dir, input bit ld, input int steps,
                              input int oor_rel, input bit noise, input string name);
        logic [NR-1:0]     sel;
        logic [3*NR+2:0]   got;
        logic [3*NR+2:0]   want;
        logic [NR-1:0]     w_move;
        int                first;
        int                done_rel;
        bit                err;
        sel = '0;
        if (rank < NR) sel[rank] = 1'b1;
        first = 2 + int'(ld);
        if (rank >= NR) begin
            done_rel = 2;
            err      = 1'b1;
        end else if (oor_rel >= 0) begin
            done_rel = oor_rel + 2;
            err      = 1'b1;
        end else begin
            done_rel = first + steps * (SG + 1);
            err      = 1'b0;
        end
        dl_req   = 1'b1;
        dl_rank  = rank[RW-1:0];
        dl_dir   = dir;
        dl_load  = ld;
        dl_steps = 8'(steps);
        tick();
        dl_req = 1'b0;
        for (int rel = 1; rel <= done_rel + 1; rel++) begin
            w_move = '0;
            for (int k = 0; k < steps; k++) begin
                if (rank < NR && rel == first + k * (SG + 1) && (oor_rel < 0 || rel <= oor_rel)) w_move = sel;
            end
            want = {w_move,
                    (ld && rel == 2) ? sel : '0,
                    (dir && rel < done_rel) ? sel : '0,
                    rel < done_rel,
                    rel == done_rel,
                    rel == done_rel && err};
            got  = {dl_move, dl_loadv, dl_direction, dl_busy, dl_done, dl_err};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s rel=%0d got=%b want=%b (move,load,dir,busy,done,err)", name, rel, got, want);
            end
            if (noise) begin
                total++;
                if (tx_data !== exp_tx(cyc)) begin
                    bad++;
                    $display("FAIL %s_odt cyc=%0d got=%b want=%b", name, cyc, tx_data, exp_tx(cyc));
                end
            end
            dl_oor = (oor_rel >= 0 && rel >= oor_rel) ? sel : '0;
            if (noise) begin
                dl_oor  = dl_oor | (NR'($urandom) & ~sel);
                dl_req  = (rel < done_rel) && ($urandom_range(0, 1) == 1);
                dl_rank = RW'($urandom);
                dl_load = 1'($urandom);
                dl_dir  = 1'($urandom);
                dl_steps = 8'($urandom_range(0, 3));
                issue($urandom_range(0, 2) == 0, $urandom_range(0, 3), NR'($urandom));
            end
            tick();
        end
        dl_oor = '0;
        dl_req = 1'b0;
        issue(1'b0, 0, '0);
    endtask

    task automatic test_adjust_directed();
        run_adjust(1, 1'b1, 1'b1, 3, -1, 1'b0, "adjust_load3");
        run_adjust(0, 1'b0, 1'b0, 0, -1, 1'b0, "adjust_zero");
        run_adjust(1, 1'b0, 1'b1, 0, -1, 1'b0, "adjust_load_only");
    endtask

    task automatic test_adjust_abort();
        run_adjust(0, 1'b1, 1'b0, 5, 5, 1'b0, "adjust_oor_gap");
        run_adjust(1, 1'b0, 1'b1, 4, 5, 1'b0, "adjust_oor_move");
    endtask

    task automatic test_adjust_random();
        int rank, steps, ld, oor_rel, first;
        cfg_odt_lat = 5'd7;
        cfg_odt_len = 4'd5;
        for (int n = 0; n < 12; n++) begin
            rank    = $urandom_range(0, NR - 1);
            ld      = $urandom_range(0, 1);
            steps   = $urandom_range(0, 4);
            first   = 2 + ld;
            oor_rel = -1;
            if (steps > 0 && $urandom_range(0, 2) == 0)
                oor_rel = $urandom_range(first - 1, first + steps * (SG + 1) - 2);
            run_adjust(rank, 1'($urandom), 1'(ld), steps, oor_rel, 1'b1, "adjust_random");
        end
    endtask

    task automatic test_adjust_reset();
        dl_req   = 1'b1;
        dl_rank  = '0;
        dl_dir   = 1'b1;
        dl_load  = 1'b0;
        dl_steps = 8'd3;
        tick();
        dl_req = 1'b0;
        tick();
        tick();
        total++;
        if (dl_busy !== 1'b1) begin
            bad++;
            $display("FAIL adjust_busy_in_gap got=%b want=1", dl_busy);
        end
        tx_sync_rst = 1'b1;
        tick();
        total++;
        if ({dl_busy, dl_done, dl_err, dl_move, dl_direction, dl_loadv} !== '0) begin
            bad++;
            $display("FAIL adjust_reset_gap got=%h want=0", {dl_busy, dl_done, dl_err, dl_move, dl_direction, dl_loadv});
        end
        tx_sync_rst = 1'b0;
        clear_model();
        tick();
        run_adjust(1, 1'b0, 1'b0, 0, -1, 1'b0, "adjust_after_reset");
    endtask

`else

    task automatic test_adjust_stub();
        for (int n = 0; n < 4; n++) begin
            dl_req   = 1'b1;
            dl_rank  = RW'($urandom);
            dl_dir   = 1'($urandom);
            dl_load  = 1'($urandom);
            dl_steps = 8'($urandom_range(1, 9));
            dl_oor   = NR'($urandom);
            tick();
            dl_req = 1'b0;
            total++;
            if ({dl_done, dl_err, dl_busy, dl_move, dl_direction, dl_loadv} !== {2'b11, 1'b0, {3*NR{1'b0}}}) begin
                bad++;
                $display("FAIL adjust_stub_done got=%b want=110 and no delay-line activity",
                         {dl_done, dl_err, dl_busy, dl_move, dl_direction, dl_loadv});
            end
            tick();
            total++;
            if ({dl_done, dl_err, dl_busy, dl_move} !== '0) begin
                bad++;
                $display("FAIL adjust_stub_idle got=%b want=0", {dl_done, dl_err, dl_busy, dl_move});
            end
        end
        dl_oor = '0;
    endtask

`endif

    initial begin
        test_reset();
        test_lat5();
        test_back_to_back();
        test_clamp();
        test_reset_window();
        test_random_odt();
`ifdef DDR3_ODT_SEQ_DLY_STEP_EN
        test_adjust_directed();
        test_adjust_abort();
        test_adjust_random();
        test_adjust_reset();
`else
        test_adjust_stub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
